t3_addsub_seq: RTL and testbench
================================

# t3_addsub_seq

Sequential, parametrised balanced-ternary add/subtract/accumulate unit: the multi-cycle successor to the combinational `t3_addition` adder. It processes CHUNK trits per clock with a registered carry trit, so wide words close timing. It adds subtract and accumulate modes, an overflow (carry-out) trit and invalid-encoding detection. Trit encoding: 2 bits per trit, `00`=0, `01`=+1, `10`=−1, `11`=invalid. Trit 0 occupies bits [1:0].

## Interface
- TRITS, 16, word width in trits; data buses are 2*TRITS bits wide.
- CHUNK, 4, trits processed per cycle. TRITS must be a multiple of CHUNK. N = TRITS/CHUNK.
- I_clk  in  1  clock; all state changes on the rising edge.
- I_rst  in  1  asynchronous, active-high reset.
- I_start  in  1  request a new operation; sampled only when idle.
- I_op  in  2  operation select:
  - `00`: out = a + b.
  - `01`: out = a − b.
  - `10`: acc = acc + a (I_b ignored).
  - `11`: clear acc.
- I_a  in  2*TRITS  operand a.
- I_b  in  2*TRITS  operand b.
- O_out  out  2*TRITS  result; holds until the next completion.
- O_carry  out  2  final carry trit; nonzero means overflow.
- O_invalid  out  1  at least one input trit was `11`.
- O_busy  out  1  operation in progress.
- O_done  out  1  one-cycle completion pulse.

## Operation
- **States:**
  - IDLE: accepts I_start.
  - RUN: chunk counter idx runs 0..N−1.
- **Start edge (IDLE, I_start=1):**
  - Latch I_op, I_a and the b operand into work registers. The b operand is:
    - I_b for `00`;
    - I_b with each trit negated for `01` (swap `01`↔`10`; `00` and `11` unchanged);
    - acc for `10`.
  - Set carry := 0, idx := 0, state := RUN, O_busy := 1.
  - Clear the sticky invalid flag.
- **RUN edge:**
  - For each of the CHUNK trits at positions idx*CHUNK.., ripple in ascending order: s = a + b + c, with s in −3..3.
  - Trit and carry from s:
    - s = 3: trit 0, carry +1.
    - s = 2: trit −1, carry +1.
    - s in −1..1: trit s, carry 0.
    - s = −2: trit +1, carry −1.
    - s = −3: trit 0, carry −1.
  - An input trit `11` is treated as 0 and sets the sticky invalid flag.
  - Result trits go to an internal result register, not O_out.
  - On the edge where idx = N−1:
    - O_out := result; O_carry := final carry; O_invalid := flag.
    - O_done := 1, O_busy := 0, state := IDLE.
    - If op = `10`: acc := result. The carry is discarded, so acc wraps modulo 3^TRITS.
- **Op `11`:** completes on the start edge without entering RUN.
  - acc := 0, O_out := 0, O_carry := `00`, O_invalid := 0.
  - O_done := 1 for the next cycle; O_busy stays 0.
- **I_start while busy:** ignored. It is not queued.
- **Input stability:** inputs only need to be stable at the start edge.
- **Reset (any time, including mid-RUN):**
  - State IDLE; O_out, O_carry, acc, idx and carry all 0.
  - O_invalid, O_busy and O_done all 0.
  - Any in-flight operation is lost; no O_done pulse.

## Timing
- **Latency:** start sampled at edge E0 → O_done high in the cycle following edge EN (N cycles; 4 by default). O_busy is high for exactly N cycles, starting after E0.
- **Clear (`11`):** O_done is high in the cycle following E0.
- **Back-to-back:** I_start asserted in the same cycle that O_done is high is accepted. Throughput is one operation per N cycles.
- **O_done:** exactly one cycle wide; deasserted on the following edge unless another clear completes.
- **O_out / O_carry / O_invalid:** change only on completion edges or reset, never mid-RUN.
- **CHUNK = TRITS:** N = 1, single-cycle latency, same protocol.

## Test plan
All cases use TRITS=16, CHUNK=4.
- **Add:**
  - a=`0x0001`, b=`0x0001`, op `00` → after 4 cycles O_out=`0x0006`, O_carry=`00`, O_done one cycle.
  - Then a=`0x0006`, b=`0x0001` → O_out=`0x0004`.
  - Then a=`0x15555555`, b=`0x0001` → O_out=`0x6AAAAAAA`.
- **Subtract and overflow:**
  - a=0, b=`0x0001`, op `01` → O_out=`0x00000002`, O_carry=`00`.
  - a=`0x55555555`, b=`0x0001`, op `00` → O_out=`0xAAAAAAAA`, O_carry=`01`.
- **Accumulate:** op `11` (O_done the next cycle, O_out=0), then three op `10` with a=`0x0001` issued back-to-back on each O_done → O_out sequence `0x0001`, `0x0006`, `0x0004`.
- **Invalid:** a=`0x00000003`, b=`0x0001` → O_invalid=1, O_out=`0x00000001`. The next valid add clears O_invalid.
- **Protocol:** I_start pulsed during RUN is ignored; O_busy stays high exactly 4 cycles; O_out holds its old value until completion.
- **Reset mid-RUN:** I_rst asserted asynchronously 2 cycles after start → all outputs 0 immediately with no clock edge, and no O_done. A following add completes normally with acc=0.

Source files
------------

// File: rtl/t3_addsub_seq.sv
// Sequential balanced-ternary add/subtract/accumulate unit: CHUNK trits per
// clock with a registered carry trit, overflow carry-out and invalid-trit flag.
module t3_addsub_seq #(
  parameter int TRITS = 16,
  parameter int CHUNK = 4
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic [1:0]         I_op,
  input  logic [2*TRITS-1:0] I_a,
  input  logic [2*TRITS-1:0] I_b,
  output logic [2*TRITS-1:0] O_out,
  output logic [1:0]         O_carry,
  output logic               O_invalid,
  output logic               O_busy,
  output logic               O_done
);
  localparam int N  = TRITS / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 2 * CHUNK;
  localparam int W  = 2 * TRITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg;
  logic [1:0]     op_reg;
  logic [W-1:0]   a_reg, b_reg, res_reg, acc_reg, out_reg;
  logic [1:0]     carry_reg, carry_out_reg;
  logic [IW-1:0]  idx_reg;
  logic           inv_reg, inv_out_reg, busy_reg, done_reg;

  logic [W-1:0]   b_neg, b_sel, res_next;
  logic [CW-1:0]  a_chunk, b_chunk, chunk_res;
  logic [1:0]     c [CHUNK+1];
  logic [CHUNK-1:0] inv_vec;
  logic           inv_next;
  logic           last_chunk;

  function automatic logic signed [3:0] dec(input logic [1:0] t);
    case (t)
      2'b01:   dec = 4'sd1;
      2'b10:   dec = -4'sd1;
      default: dec = 4'sd0;
    endcase
  endfunction

  function automatic logic [1:0] enc(input logic signed [3:0] v);
    if (v == 4'sd1)       enc = 2'b01;
    else if (v == -4'sd1) enc = 2'b10;
    else                  enc = 2'b00;
  endfunction

  // Negating a trit is a swap of its two encoding bits; 00 and 11 map to themselves.
  genvar gi;
  generate
    for (gi = 0; gi < TRITS; gi++) begin : g_neg
      assign b_neg[2*gi +: 2] = {I_b[2*gi], I_b[2*gi+1]};
    end
  endgenerate

  always_comb begin
    b_sel = I_b;
    case (I_op)
      2'b01:   b_sel = b_neg;
      2'b10:   b_sel = acc_reg;
      default: b_sel = I_b;
    endcase
  end

  assign a_chunk = a_reg[idx_reg*CW +: CW];
  assign b_chunk = b_reg[idx_reg*CW +: CW];
  assign c[0]    = carry_reg;

  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_trit
      logic [1:0]        ta, tb;
      logic signed [3:0] s, t;
      logic [1:0]        co;
      assign ta = a_chunk[2*gi +: 2];
      assign tb = b_chunk[2*gi +: 2];
      assign s  = dec(ta) + dec(tb) + dec(c[gi]);
      always_comb begin
        t  = s;
        co = 2'b00;
        if (s > 4'sd1) begin
          t  = s - 4'sd3;
          co = 2'b01;
        end else if (s < -4'sd1) begin
          t  = s + 4'sd3;
          co = 2'b10;
        end
      end
      assign chunk_res[2*gi +: 2] = enc(t);
      assign c[gi+1]              = co;
      assign inv_vec[gi]          = (&ta) | (&tb);
    end
  endgenerate

  always_comb begin
    res_next = res_reg;
    res_next[idx_reg*CW +: CW] = chunk_res;
  end

  assign inv_next   = inv_reg | (|inv_vec);
  assign last_chunk = (idx_reg == IW'(N - 1));

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_reg     <= IDLE;
      op_reg        <= 2'b00;
      a_reg         <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
      carry_reg     <= 2'b00;
      carry_out_reg <= 2'b00;
      idx_reg       <= '0;
      inv_reg       <= 1'b0;
      inv_out_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (I_start) begin
            if (I_op == 2'b11) begin
              // Clear finishes on the start edge without entering RUN.
              acc_reg       <= '0;
              out_reg       <= '0;
              carry_out_reg <= 2'b00;
              inv_out_reg   <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              op_reg    <= I_op;
              a_reg     <= I_a;
              b_reg     <= b_sel;
              carry_reg <= 2'b00;
              idx_reg   <= '0;
              inv_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= c[CHUNK];
          inv_reg   <= inv_next;
          idx_reg   <= idx_reg + 1'b1;
          if (last_chunk) begin
            out_reg       <= res_next;
            carry_out_reg <= c[CHUNK];
            inv_out_reg   <= inv_next;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            idx_reg       <= '0;
            state_reg     <= IDLE;
            // Accumulator drops the carry, so it wraps modulo 3^TRITS.
            if (op_reg == 2'b10) acc_reg <= res_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign O_out     = out_reg;
  assign O_carry   = carry_out_reg;
  assign O_invalid = inv_out_reg;
  assign O_busy    = busy_reg;
  assign O_done    = done_reg;
endmodule

// File: tb/tb_t3_addsub_seq.sv
// Randomized and directed bench for t3_addsub_seq against an integer-valued
// balanced-ternary reference model.
module tb_t3_addsub_seq;
  localparam int TRITS = 16;
  localparam int CHUNK = 4;
  localparam int N     = TRITS / CHUNK;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] out;
  logic [1:0]  carry;
  logic        invalid, busy, done;

  int errors = 0;
  int checks = 0;

  longint      acc_m = 0;
  logic [31:0] exp_out, last_out;
  logic [1:0]  exp_carry;
  logic        exp_inv;

  always #5 clk = ~clk;

  t3_addsub_seq #(.TRITS(TRITS), .CHUNK(CHUNK)) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_op(op), .I_a(a), .I_b(b),
    .O_out(out), .O_carry(carry), .O_invalid(invalid), .O_busy(busy), .O_done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic longint tval(input logic [1:0] t);
    if (t == 2'b01) return 1;
    if (t == 2'b10) return -1;
    return 0;
  endfunction

  function automatic longint wval(input logic [31:0] w);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < TRITS; i++) begin
      v += tval(w[2*i +: 2]) * p;
      p *= 3;
    end
    return v;
  endfunction

  function automatic logic has_inv(input logic [31:0] w);
    for (int i = 0; i < TRITS; i++)
      if (w[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  // Plain integer-to-balanced-ternary conversion; the leftover is the carry trit.
  task automatic encode(input longint v_in, output logic [31:0] w, output logic [1:0] c);
    longint v = v_in;
    longint r;
    w = '0;
    for (int i = 0; i < TRITS; i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 1) begin w[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
      else if (r == 2) begin w[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
      else v = v / 3;
    end
    c = (v == 1) ? 2'b01 : (v == -1) ? 2'b10 : 2'b00;
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint v;
    case (o)
      2'b00: begin v = wval(av) + wval(bv); exp_inv = has_inv(av) | has_inv(bv); end
      2'b01: begin v = wval(av) - wval(bv); exp_inv = has_inv(av) | has_inv(bv); end
      2'b10: begin v = wval(av) + acc_m;    exp_inv = has_inv(av); end
      default: begin v = 0; exp_inv = 1'b0; end
    endcase
    encode(v, exp_out, exp_carry);
    if (o == 2'b10) acc_m = wval(exp_out);
    if (o == 2'b11) acc_m = 0;
  endtask

  function automatic logic [31:0] rand_word(input int inv_pct);
    logic [31:0] w;
    int r;
    for (int i = 0; i < TRITS; i++) begin
      r = $urandom_range(0, 99);
      if (r < inv_pct) w[2*i +: 2] = 2'b11;
      else w[2*i +: 2] = (r % 3 == 0) ? 2'b00 : (r % 3 == 1) ? 2'b01 : 2'b10;
    end
    return w;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit poke, input string tag);
    int cycles;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    model(o, av, bv);
    if (o == 2'b11) begin
      check({tag, "_clr_done"}, done, 1);
      check({tag, "_clr_busy"}, busy, 0);
    end else begin
      cycles = 0;
      while (done !== 1'b1 && cycles < 3 * N) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_hold"}, out, last_out);
        start = (poke && cycles == 1);
        @(posedge clk);
        #1;
        cycles++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cycles, N);
      check({tag, "_busy_end"}, busy, 0);
    end
    check({tag, "_out"}, out, exp_out);
    check({tag, "_carry"}, carry, exp_carry);
    check({tag, "_inv"}, invalid, exp_inv);
    $display("op=%0d a=%h b=%h -> out=%h carry=%b inv=%b (%s)", o, av, bv, out, carry, invalid, tag);
    last_out = exp_out;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    last_out = '0;
    #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_inv", invalid, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'h1, 32'h1, 0, "add1");
    check("add1_lit", out, 32'h6);
    run_op(2'b00, 32'h6, 32'h1, 0, "add2");
    check("add2_lit", out, 32'h4);
    run_op(2'b00, 32'h15555555, 32'h1, 0, "add3");
    check("add3_lit", out, 32'h6AAAAAAA);
    run_op(2'b01, 32'h0, 32'h1, 0, "sub1");
    check("sub1_lit", out, 32'h2);
    run_op(2'b00, 32'h55555555, 32'h1, 0, "ovf");
    check("ovf_lit", out, 32'hAAAAAAAA);
    check("ovf_carry_lit", carry, 2'b01);

    run_op(2'b11, 32'h0, 32'h0, 0, "clr");
    run_op(2'b10, 32'h1, 32'h0, 0, "acc1");
    check("acc1_lit", out, 32'h1);
    run_op(2'b10, 32'h1, 32'h0, 0, "acc2");
    check("acc2_lit", out, 32'h6);
    run_op(2'b10, 32'h1, 32'h0, 0, "acc3");
    check("acc3_lit", out, 32'h4);

    run_op(2'b00, 32'h3, 32'h1, 0, "inv");
    check("inv_lit", invalid, 1);
    check("inv_out_lit", out, 32'h1);
    run_op(2'b00, 32'h1, 32'h1, 0, "inv_clear");
    check("inv_clear_lit", invalid, 0);

    run_op(2'b00, 32'h5, 32'h9, 1, "poke");
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("poke_idle", busy, 0);

    // Asynchronous reset in the middle of a RUN.
    @(negedge clk);
    op = 2'b00; a = 32'h1; b = 32'h1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_carry", carry, 0);
    @(negedge clk);
    rst = 1'b0;
    acc_m = 0; last_out = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", done, 0);
    end
    run_op(2'b10, 32'h1, 32'h0, 0, "post_rst_acc");
    check("post_rst_acc_lit", out, 32'h1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      ro = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op(ro, rand_word(3), rand_word(3), ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
